// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the data bus arbiter.
//   - arb_state_e : arbiter FSM states (idle / bus owned)
//   - OwnerW      : width of the owner index carried on arb_owner
//   - MstDbg/MstCpu/MstDma : requester indices on the m_* vectors
//   - rr_index()  : cyclic index helper used by the round-robin picker
package data_bus_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StOwned = 1'b1
  } arb_state_e;

  localparam int unsigned OwnerW = 2;

  localparam int unsigned MstDbg = 0;
  localparam int unsigned MstCpu = 1;
  localparam int unsigned MstDma = 2;

  // Index reached k steps after 'last' on a ring of n requesters.
  function automatic int unsigned rr_index(int unsigned last, int unsigned k, int unsigned n);
    return (last + k) % n;
  endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Bus bundle between the bus masters and the arbiter.
//   m_bus_req/m_addr/m_wr/m_rd/m_dout : per-master request side (master i at slice i)
//   m_bus_grant                       : per-master registered grant
//   s_addr/s_wr/s_rd/s_dout           : shared bus towards memory / peripherals
//   arb_busy/arb_owner/arb_timeout    : arbiter status
// Modports: master = requester/observer side, slave = arbiter side.
interface data_bus_arbiter_if
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8
);

  logic [NUM_MASTERS-1:0]        m_bus_req;
  logic [NUM_MASTERS-1:0]        m_bus_grant;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS-1:0]        m_wr;
  logic [NUM_MASTERS-1:0]        m_rd;
  logic [NUM_MASTERS*DATA_W-1:0] m_dout;
  logic [ADDR_W-1:0]             s_addr;
  logic                          s_wr;
  logic                          s_rd;
  logic [DATA_W-1:0]             s_dout;
  logic                          arb_busy;
  logic [OwnerW-1:0]             arb_owner;
  logic                          arb_timeout;

  modport master (
    output m_bus_req, m_addr, m_wr, m_rd, m_dout,
    input  m_bus_grant, s_addr, s_wr, s_rd, s_dout, arb_busy, arb_owner, arb_timeout
  );

  modport slave (
    input  m_bus_req, m_addr, m_wr, m_rd, m_dout,
    output m_bus_grant, s_addr, s_wr, s_rd, s_dout, arb_busy, arb_owner, arb_timeout
  );

endinterface

// File: rtl/data_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker.
//   req_i        : eligible request vector
//   last_owner_i : index of the previous owner; search starts just after it
//   winner_oh_o  : one-hot winner (zero when no request)
//   winner_idx_o : index of the winner
//   valid_o      : a winner exists
module data_bus_arbiter_rr_priority_picker
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [OwnerW-1:0]      last_owner_i,
  output logic [NUM_MASTERS-1:0] winner_oh_o,
  output logic [OwnerW-1:0]      winner_idx_o,
  output logic                   valid_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    idx          = 0;
    found        = 1'b0;
    winner_oh_o  = '0;
    winner_idx_o = '0;
    // Walk the ring starting one past the last owner; the last owner itself is
    // visited last, so a lone requester can still win twice in a row.
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      idx = rr_index(int'(last_owner_i), k, NUM_MASTERS);
      if (!found && req_i[idx]) begin
        found            = 1'b1;
        winner_oh_o[idx] = 1'b1;
        winner_idx_o     = OwnerW'(idx);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin data bus arbiter for MiniRISC masters (0=debug, 1=CPU, 2=DMA).
// Grants one requester at a time (registered one-hot grant, 1 clk latency),
// holds the grant while the owner keeps its request high, and inserts at least
// one dead cycle between owners. The shared bus is muxed combinationally from
// the registered owner; non-owners never reach it.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : data_bus_arbiter_if.slave bundle (requests in, grants/shared bus out)
// Build option: define ARB_TIMEOUT_EN to bound ownership to MAX_HOLD cycles;
// a revoked master is masked until its request has been seen low once.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_HOLD    = 255
) (
  input logic               clk,
  input logic               rst,
  data_bus_arbiter_if.slave bus
);

  if (NUM_MASTERS < 1 || NUM_MASTERS > (1 << OwnerW)) begin : g_bad_masters
    $error("NUM_MASTERS out of range for the owner index width");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("MAX_HOLD must be at least 1");
  end

  arb_state_e               state_q, state_d;
  logic [NUM_MASTERS-1:0]   grant_q, grant_d;
  logic [OwnerW-1:0]        owner_q, owner_d;
  logic [OwnerW-1:0]        last_owner_q, last_owner_d;
  logic [NUM_MASTERS-1:0]   eligible;
  logic [NUM_MASTERS-1:0]   pick_oh;
  logic [OwnerW-1:0]        pick_idx;
  logic                     pick_valid;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;
  logic                   timeout_q, timeout_d;

  assign eligible = bus.m_bus_req & ~mask_q;
`else
  assign eligible = bus.m_bus_req;
`endif

  data_bus_arbiter_rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .req_i        (eligible),
    .last_owner_i (last_owner_q),
    .winner_oh_o  (pick_oh),
    .winner_idx_o (pick_idx),
    .valid_o      (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d   = hold_cnt_q;
    timeout_d    = 1'b0;
    // A mask bit survives only while that master keeps requesting.
    mask_d       = mask_q & bus.m_bus_req;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d      = pick_oh;
          owner_d      = pick_idx;
          last_owner_d = pick_idx;
          state_d      = StOwned;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d   = '0;
`endif
        end
      end
      StOwned: begin
        if (!bus.m_bus_req[owner_q]) begin
          grant_d = '0;
          state_d = StIdle;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_q == HoldW'(MAX_HOLD - 1)) begin
          // Counter reaches MAX_HOLD-1 on the edge closing the MAX_HOLD-th owned cycle.
          grant_d         = '0;
          state_d         = StIdle;
          timeout_d       = 1'b1;
          mask_d[owner_q] = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      owner_q      <= '0;
      // Start "after" the last master so master 0 wins the first arbitration.
      last_owner_q <= OwnerW'(NUM_MASTERS - 1);
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q   <= '0;
      mask_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q   <= hold_cnt_d;
      mask_q       <= mask_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  // Shared bus mux; everything derives from reset-cleared flops so it drops
  // asynchronously with rst.
  always_comb begin
    bus.s_addr = '0;
    bus.s_dout = '0;
    if (state_q == StOwned) begin
      bus.s_addr = bus.m_addr[int'(owner_q) * ADDR_W +: ADDR_W];
      bus.s_dout = bus.m_dout[int'(owner_q) * DATA_W +: DATA_W];
    end
  end

  assign bus.s_wr        = bus.m_wr[owner_q] & grant_q[owner_q];
  assign bus.s_rd        = bus.m_rd[owner_q] & grant_q[owner_q];
  assign bus.m_bus_grant = grant_q;
  assign bus.arb_busy    = (state_q == StOwned);
  assign bus.arb_owner   = owner_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.arb_timeout = timeout_q;
`else
  assign bus.arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed, table-driven bench for data_bus_arbiter (3 masters, 8-bit bus, MAX_HOLD=4).
module tb_data_bus_arbiter;
  import data_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_bus_arbiter_if #(.NUM_MASTERS(3), .ADDR_W(8), .DATA_W(8)) bus_if ();

  data_bus_arbiter #(
    .NUM_MASTERS (3),
    .ADDR_W      (8),
    .DATA_W      (8),
    .MAX_HOLD    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Fixed per-master bus contents: debug writes to 0x40.
  localparam logic [7:0] AddrDbg = 8'h40, AddrCpu = 8'h22, AddrDma = 8'h33;
  localparam logic [7:0] DataDbg = 8'hA0, DataCpu = 8'hB1, DataDma = 8'hC2;

  typedef struct {
    logic [2:0] req, wr, rd;
    logic [2:0] exp_grant;
    logic [1:0] exp_owner;
    logic       exp_busy, exp_wr, exp_rd;
    logic [7:0] exp_addr, exp_dout;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] g, input logic [1:0] o,
                         input logic b, input logic w, input logic r,
                         input logic [7:0] a, input logic [7:0] d, input logic t);
    chk({tag, ".grant"}, 32'(bus_if.m_bus_grant), 32'(g));
    chk({tag, ".owner"}, 32'(bus_if.arb_owner), 32'(o));
    chk({tag, ".busy"}, 32'(bus_if.arb_busy), 32'(b));
    chk({tag, ".s_wr"}, 32'(bus_if.s_wr), 32'(w));
    chk({tag, ".s_rd"}, 32'(bus_if.s_rd), 32'(r));
    chk({tag, ".s_addr"}, 32'(bus_if.s_addr), 32'(a));
    chk({tag, ".s_dout"}, 32'(bus_if.s_dout), 32'(d));
    chk({tag, ".timeout"}, 32'(bus_if.arb_timeout), 32'(t));
  endtask

  task automatic add(input logic [2:0] req, input logic [2:0] wr, input logic [2:0] rd,
                     input logic [2:0] g, input logic [1:0] o, input logic b,
                     input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    vec_t v;
    v.req = req; v.wr = wr; v.rd = rd; v.exp_grant = g; v.exp_owner = o;
    v.exp_busy = b; v.exp_wr = w; v.exp_rd = r; v.exp_addr = a; v.exp_dout = d;
    vecs.push_back(v);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] req, input logic [2:0] wr, input logic [2:0] rd);
    bus_if.m_bus_req = req;
    bus_if.m_wr      = wr;
    bus_if.m_rd      = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.m_addr = {AddrDma, AddrCpu, AddrDbg};
    bus_if.m_dout = {DataDma, DataCpu, DataDbg};
    drive(3'b000, 3'b000, 3'b000);

    //   req     wr      rd      grant   own  busy wr  rd  addr     dout
    // Single CPU request; then debug strobes while CPU owns the bus.
    add(3'b010, 3'b010, 3'b000, 3'b010, 2'd1, 1, 1, 0, AddrCpu, DataCpu);
    add(3'b011, 3'b001, 3'b000, 3'b010, 2'd1, 1, 0, 0, AddrCpu, DataCpu);
    add(3'b001, 3'b001, 3'b000, 3'b000, 2'd1, 0, 0, 0, 8'h00,   8'h00);
    add(3'b001, 3'b000, 3'b001, 3'b001, 2'd0, 1, 0, 1, AddrDbg, DataDbg);
    // Owner drops with 101 pending: one dead cycle, then DMA.
    add(3'b101, 3'b100, 3'b101, 3'b001, 2'd0, 1, 0, 1, AddrDbg, DataDbg);
    add(3'b100, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0, 0, 8'h00,   8'h00);
    add(3'b100, 3'b100, 3'b000, 3'b100, 2'd2, 1, 1, 0, AddrDma, DataDma);
    add(3'b000, 3'b000, 3'b000, 3'b000, 2'd2, 0, 0, 0, 8'h00,   8'h00);
    // All request; each owner holds 2 clks then drops for one.
    add(3'b111, 3'b000, 3'b000, 3'b001, 2'd0, 1, 0, 0, AddrDbg, DataDbg);
    add(3'b111, 3'b000, 3'b000, 3'b001, 2'd0, 1, 0, 0, AddrDbg, DataDbg);
    add(3'b110, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0, 0, 8'h00,   8'h00);
    add(3'b111, 3'b000, 3'b000, 3'b010, 2'd1, 1, 0, 0, AddrCpu, DataCpu);
    add(3'b111, 3'b000, 3'b000, 3'b010, 2'd1, 1, 0, 0, AddrCpu, DataCpu);
    add(3'b101, 3'b000, 3'b000, 3'b000, 2'd1, 0, 0, 0, 8'h00,   8'h00);
    add(3'b111, 3'b000, 3'b000, 3'b100, 2'd2, 1, 0, 0, AddrDma, DataDma);
    add(3'b111, 3'b000, 3'b000, 3'b100, 2'd2, 1, 0, 0, AddrDma, DataDma);
    add(3'b011, 3'b000, 3'b000, 3'b000, 2'd2, 0, 0, 0, 8'h00,   8'h00);
    add(3'b111, 3'b000, 3'b000, 3'b001, 2'd0, 1, 0, 0, AddrDbg, DataDbg);
    add(3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0, 0, 8'h00,   8'h00);

    // Reset state
    step();
    step();
    chk_all("reset", 3'b000, 2'd0, 0, 0, 0, 8'h00, 8'h00, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].wr, vecs[i].rd);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_owner,
              vecs[i].exp_busy, vecs[i].exp_wr, vecs[i].exp_rd,
              vecs[i].exp_addr, vecs[i].exp_dout, 1'b0);
    end

    // Request pulse that never spans an edge is ignored.
    drive(3'b010, 3'b010, 3'b000);
    #3;
    drive(3'b000, 3'b000, 3'b000);
    step();
    chk_all("glitch", 3'b000, 2'd0, 0, 0, 0, 8'h00, 8'h00, 0);

    // Asynchronous reset in the middle of a CPU write.
    drive(3'b010, 3'b010, 3'b000);
    step();
    chk_all("pre_rst", 3'b010, 2'd1, 1, 1, 0, AddrCpu, DataCpu, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.grant", 32'(bus_if.m_bus_grant), 32'd0);
    chk("async_rst.s_wr", 32'(bus_if.s_wr), 32'd0);
    chk("async_rst.busy", 32'(bus_if.arb_busy), 32'd0);
    step();
    rst = 1'b0;
    drive(3'b111, 3'b000, 3'b000);
    step();
    chk_all("post_rst", 3'b001, 2'd0, 1, 0, 0, AddrDbg, DataDbg, 0);
    drive(3'b000, 3'b000, 3'b000);
    step();
    chk_all("post_rst_rel", 3'b000, 2'd0, 0, 0, 0, 8'h00, 8'h00, 0);

`ifdef ARB_TIMEOUT_EN
    // CPU holds its request: revoked after 4 owned cycles, then masked.
    drive(3'b010, 3'b000, 3'b000);
    step();
    chk_all("to_grant", 3'b010, 2'd1, 1, 0, 0, AddrCpu, DataCpu, 0);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk_all($sformatf("to_hold%0d", c), 3'b010, 2'd1, 1, 0, 0, AddrCpu, DataCpu, 0);
    end
    step();
    chk_all("to_revoke", 3'b000, 2'd1, 0, 0, 0, 8'h00, 8'h00, 1);
    step();
    chk_all("to_masked", 3'b000, 2'd1, 0, 0, 0, 8'h00, 8'h00, 0);
    drive(3'b110, 3'b000, 3'b000);
    step();
    chk_all("to_dma", 3'b100, 2'd2, 1, 0, 0, AddrDma, DataDma, 0);
    drive(3'b010, 3'b000, 3'b000);
    step();
    chk_all("to_dma_rel", 3'b000, 2'd2, 0, 0, 0, 8'h00, 8'h00, 0);
    step();
    chk_all("to_still_masked", 3'b000, 2'd2, 0, 0, 0, 8'h00, 8'h00, 0);
    drive(3'b000, 3'b000, 3'b000);
    step();
    drive(3'b010, 3'b000, 3'b000);
    step();
    chk_all("to_regrant", 3'b010, 2'd1, 1, 0, 0, AddrCpu, DataCpu, 0);
    drive(3'b000, 3'b000, 3'b000);
    step();
`else
    // Without the timeout option ownership is unbounded.
    drive(3'b010, 3'b000, 3'b000);
    for (int c = 0; c < 8; c++) begin
      step();
      chk_all($sformatf("hold%0d", c), 3'b010, 2'd1, 1, 0, 0, AddrCpu, DataCpu, 0);
    end
    drive(3'b000, 3'b000, 3'b000);
    step();
    chk_all("hold_rel", 3'b000, 2'd1, 0, 0, 0, 8'h00, 8'h00, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
